board_game_control_p: RTL and testbench

- Parametrised turn-sequencing FSM for grid board games; successor to the fixed 8x8, two-player chess controller.
- Drives the cursor box, latches source/destination squares, enforces piece ownership, and performs a real req/ack handshake with an external move validator (with timeout).
- Commits moves, detects a king capture, and rotates among N players.
- Sits between the input debouncers, board memory arbiter, move validator and board datapath.

---
 rtl/board_game_control_p.sv | 238 +++++++++++++++++++++++
 tb/tb_board_game_control_p.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_game_control_p.sv
// Turn-sequencing controller for grid board games: cursor, source/destination latching,
// validator handshake with timeout, move commit, king-capture detection and player rotation.
module board_game_control_p #(
    parameter int unsigned BOARD_W     = 8,
    parameter int unsigned BOARD_H     = 8,
    parameter int unsigned COORD_W     = 3,
    parameter int unsigned PIECE_W     = 4,
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned PLAYER_W    = 1,
    parameter int unsigned BOX_DIV     = 12500000,
    parameter int unsigned WRAP        = 1,
    parameter int unsigned VAL_TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                up,
    input  logic                down,
    input  logic                left,
    input  logic                right,
    input  logic                select,
    input  logic                deselect,
    input  logic [PIECE_W-1:0]  sq_piece,
    input  logic [PLAYER_W-1:0] sq_owner,
    input  logic                sq_is_king,
    input  logic                init_done,
    input  logic                val_ack,
    input  logic                val_ok,
    output logic [COORD_W-1:0]  box_x,
    output logic [COORD_W-1:0]  box_y,
    output logic [COORD_W-1:0]  piece_x,
    output logic [COORD_W-1:0]  piece_y,
    output logic [COORD_W-1:0]  move_x,
    output logic [COORD_W-1:0]  move_y,
    output logic [PIECE_W-1:0]  piece_to_move,
    output logic [PLAYER_W-1:0] current_player,
    output logic                val_req,
    output logic [1:0]          mem_sel,
    output logic                init_board,
    output logic                move_piece,
    output logic                winning,
    output logic [PLAYER_W-1:0] winner
);

    localparam int unsigned STEP_W = (BOX_DIV > 1) ? $clog2(BOX_DIV) : 1;
    localparam int unsigned VCNT_W = (VAL_TIMEOUT > 1) ? $clog2(VAL_TIMEOUT) : 1;

    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(BOX_DIV - 1);
    localparam logic [VCNT_W-1:0]   VCNT_LAST = VCNT_W'(VAL_TIMEOUT - 1);
    localparam logic [COORD_W-1:0]  X_MAX     = COORD_W'(BOARD_W - 1);
    localparam logic [COORD_W-1:0]  Y_MAX     = COORD_W'(BOARD_H - 1);
    localparam logic [PLAYER_W-1:0] P_LAST    = PLAYER_W'(NUM_PLAYERS - 1);
    localparam logic                DO_WRAP   = (WRAP != 0);

    typedef enum logic [2:0] {
        StInit,
        StSel,
        StDest,
        StVal,
        StCommit,
        StOver
    } state_e;

    state_e state_q, state_d;

    logic              select_q;
    logic              deselect_q;
    logic              sel_rise;
    logic              desel_rise;
    logic              src_valid;
    logic              dest_king_q;
    logic [VCNT_W-1:0] val_cnt_q;
    logic [STEP_W-1:0] step_cnt_q;

    logic              cursor_en;
    logic              latch_src;
    logic              latch_dst;
    logic              any_dir;
    logic              step;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic [PLAYER_W-1:0] player_next;

    assign sel_rise    = select & ~select_q;
    assign desel_rise  = deselect & ~deselect_q;
    assign src_valid   = (sq_piece != '0) && (sq_owner == current_player);
    assign any_dir     = up | down | left | right;
    assign step        = cursor_en && any_dir && (step_cnt_q == '0);
    assign player_next = (current_player == P_LAST) ? '0 : current_player + PLAYER_W'(1);

    // Next state and Moore-style strobes
    always_comb begin
        state_d    = state_q;
        init_board = 1'b0;
        val_req    = 1'b0;
        mem_sel    = 2'b00;
        move_piece = 1'b0;
        cursor_en  = 1'b0;
        latch_src  = 1'b0;
        latch_dst  = 1'b0;
        unique case (state_q)
            StInit: begin
                init_board = 1'b1;
                if (init_done) state_d = StSel;
            end
            StSel: begin
                cursor_en = 1'b1;
                if (sel_rise && src_valid) begin
                    latch_src = 1'b1;
                    state_d   = StDest;
                end
            end
            StDest: begin
                cursor_en = 1'b1;
                if (desel_rise) begin
                    state_d = StSel;
                end else if (sel_rise) begin
                    latch_dst = 1'b1;
                    state_d   = StVal;
                end
            end
            StVal: begin
                val_req = 1'b1;
                mem_sel = 2'b01;
                if (val_ack) begin
                    state_d = val_ok ? StCommit : StDest;
                end else if (val_cnt_q == VCNT_LAST) begin
                    state_d = StDest;
                end
            end
            StCommit: begin
                move_piece = 1'b1;
                mem_sel    = 2'b10;
                state_d    = dest_king_q ? StOver : StSel;
            end
            StOver: begin
            end
            default: state_d = StInit;
        endcase
    end

    // Cursor next position; opposing buttons on one axis cancel
    always_comb begin
        x_next = box_x;
        y_next = box_y;
        if (right && !left) begin
            if (box_x == X_MAX) x_next = DO_WRAP ? '0 : X_MAX;
            else                x_next = box_x + COORD_W'(1);
        end else if (left && !right) begin
            if (box_x == '0) x_next = DO_WRAP ? X_MAX : '0;
            else             x_next = box_x - COORD_W'(1);
        end
        if (up && !down) begin
            if (box_y == Y_MAX) y_next = DO_WRAP ? '0 : Y_MAX;
            else                y_next = box_y + COORD_W'(1);
        end else if (down && !up) begin
            if (box_y == '0) y_next = DO_WRAP ? Y_MAX : '0;
            else             y_next = box_y - COORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            select_q   <= 1'b0;
            deselect_q <= 1'b0;
            val_cnt_q  <= '0;
            step_cnt_q <= '0;
        end else begin
            select_q   <= select;
            deselect_q <= deselect;
            val_cnt_q  <= (state_q == StVal) ? val_cnt_q + VCNT_W'(1) : '0;
            if (cursor_en && any_dir) begin
                step_cnt_q <= (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + STEP_W'(1);
            end else begin
                step_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            box_x <= '0;
            box_y <= '0;
        end else if (state_q == StInit) begin
            box_x <= '0;
            box_y <= '0;
        end else if (step) begin
            box_x <= x_next;
            box_y <= y_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            piece_x       <= '0;
            piece_y       <= '0;
            piece_to_move <= '0;
            move_x        <= '0;
            move_y        <= '0;
            dest_king_q   <= 1'b0;
        end else begin
            if (latch_src) begin
                piece_x       <= box_x;
                piece_y       <= box_y;
                piece_to_move <= sq_piece;
            end
            if (latch_dst) begin
                move_x      <= box_x;
                move_y      <= box_y;
                dest_king_q <= sq_is_king;
            end
        end
    end

    // Capturing a king ends the game; the capturing player keeps the turn
    always_ff @(posedge clk) begin
        if (reset) begin
            current_player <= '0;
            winning        <= 1'b0;
            winner         <= '0;
        end else if (state_q == StCommit) begin
            if (dest_king_q) begin
                winning <= 1'b1;
                winner  <= current_player;
            end else begin
                current_player <= player_next;
            end
        end
    end

endmodule

// File: tb/tb_board_game_control_p.sv
// Directed bench for board_game_control_p: cursor table, selection, validator handshake,
// player rotation, king capture and game-over hold. A second instance checks edge clamping.
module tb_board_game_control_p;

    logic       clk = 1'b0;
    logic       reset;
    logic       up, down, left, right, select, deselect;
    logic [3:0] sq_piece;
    logic [1:0] sq_owner;
    logic       sq_is_king, init_done, val_ack, val_ok;

    logic [2:0] box_x, box_y, piece_x, piece_y, move_x, move_y;
    logic [3:0] piece_to_move;
    logic [1:0] current_player, winner;
    logic       val_req, init_board, move_piece, winning;
    logic [1:0] mem_sel;

    logic [2:0] c_box_x, c_box_y, c_piece_x, c_piece_y, c_move_x, c_move_y;
    logic [3:0] c_piece_to_move;
    logic [1:0] c_current_player, c_winner, c_mem_sel;
    logic       c_val_req, c_init_board, c_move_piece, c_winning;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    board_game_control_p #(
        .NUM_PLAYERS(3), .PLAYER_W(2), .BOX_DIV(4), .WRAP(1), .VAL_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
        .select(select), .deselect(deselect), .sq_piece(sq_piece), .sq_owner(sq_owner),
        .sq_is_king(sq_is_king), .init_done(init_done), .val_ack(val_ack), .val_ok(val_ok),
        .box_x(box_x), .box_y(box_y), .piece_x(piece_x), .piece_y(piece_y),
        .move_x(move_x), .move_y(move_y), .piece_to_move(piece_to_move),
        .current_player(current_player), .val_req(val_req), .mem_sel(mem_sel),
        .init_board(init_board), .move_piece(move_piece), .winning(winning), .winner(winner)
    );

    board_game_control_p #(
        .NUM_PLAYERS(3), .PLAYER_W(2), .BOX_DIV(4), .WRAP(0), .VAL_TIMEOUT(8)
    ) dut_clamp (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
        .select(select), .deselect(deselect), .sq_piece(sq_piece), .sq_owner(sq_owner),
        .sq_is_king(sq_is_king), .init_done(init_done), .val_ack(val_ack), .val_ok(val_ok),
        .box_x(c_box_x), .box_y(c_box_y), .piece_x(c_piece_x), .piece_y(c_piece_y),
        .move_x(c_move_x), .move_y(c_move_y), .piece_to_move(c_piece_to_move),
        .current_player(c_current_player), .val_req(c_val_req), .mem_sel(c_mem_sel),
        .init_board(c_init_board), .move_piece(c_move_piece), .winning(c_winning),
        .winner(c_winner)
    );

    typedef struct {
        logic [3:0] dir;  // {up, down, left, right}
        int         ex;
        int         ey;
        int         cx;
        int         cy;
    } cur_vec_t;

    typedef struct {
        logic [1:0] owner;
        logic       king;
        int         exp_player;
        int         exp_winning;
        int         exp_winner;
    } move_vec_t;

    cur_vec_t  cv [26];
    move_vec_t mv [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One idle cycle guarantees the edge detector sees a fresh rising edge
    task automatic press(input logic s, input logic d);
        select = 1'b0; deselect = 1'b0;
        tick();
        select = s; deselect = d;
        tick();
        select = 1'b0; deselect = 1'b0;
    endtask

    task automatic ack(input logic ok);
        val_ack = 1'b1; val_ok = ok;
        tick();
        val_ack = 1'b0; val_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int hold_bad;

        cv[0]  = '{4'b0010, 7, 0, 0, 0};
        cv[1]  = '{4'b0010, 7, 0, 0, 0};
        cv[2]  = '{4'b0010, 7, 0, 0, 0};
        cv[3]  = '{4'b0010, 7, 0, 0, 0};
        cv[4]  = '{4'b0010, 6, 0, 0, 0};
        cv[5]  = '{4'b0010, 6, 0, 0, 0};
        cv[6]  = '{4'b0010, 6, 0, 0, 0};
        cv[7]  = '{4'b0010, 6, 0, 0, 0};
        cv[8]  = '{4'b0010, 5, 0, 0, 0};
        cv[9]  = '{4'b0000, 5, 0, 0, 0};
        cv[10] = '{4'b1001, 6, 1, 1, 1};
        cv[11] = '{4'b0000, 6, 1, 1, 1};
        cv[12] = '{4'b1101, 7, 1, 2, 1};
        cv[13] = '{4'b0000, 7, 1, 2, 1};
        cv[14] = '{4'b0001, 0, 1, 3, 1};
        cv[15] = '{4'b0000, 0, 1, 3, 1};
        cv[16] = '{4'b0001, 1, 1, 4, 1};
        cv[17] = '{4'b0000, 1, 1, 4, 1};
        cv[18] = '{4'b0100, 1, 0, 4, 0};
        cv[19] = '{4'b0000, 1, 0, 4, 0};
        cv[20] = '{4'b0100, 1, 7, 4, 0};
        cv[21] = '{4'b0000, 1, 7, 4, 0};
        cv[22] = '{4'b1000, 1, 0, 4, 1};
        cv[23] = '{4'b0000, 1, 0, 4, 1};
        cv[24] = '{4'b1000, 1, 1, 4, 2};
        cv[25] = '{4'b0000, 1, 1, 4, 2};

        mv[0] = '{2'd1, 1'b0, 2, 0, 0};
        mv[1] = '{2'd2, 1'b0, 0, 0, 0};
        mv[2] = '{2'd0, 1'b0, 1, 0, 0};
        mv[3] = '{2'd1, 1'b1, 1, 1, 1};

        reset = 1'b1;
        {up, down, left, right, select, deselect} = '0;
        sq_piece = '0; sq_owner = '0; sq_is_king = 1'b0;
        init_done = 1'b0; val_ack = 1'b0; val_ok = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_box_x", box_x, 0);
        chk("rst_box_y", box_y, 0);
        chk("rst_player", current_player, 0);
        chk("rst_val_req", val_req, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_move_piece", move_piece, 0);
        chk("rst_winning", winning, 0);
        chk("rst_piece", piece_to_move, 0);

        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (init_board) n++;
            if (i == 4) init_done = 1'b1;
            tick();
        end
        chk("init_cycles", n, 5);
        chk("init_board_off", init_board, 0);

        for (int i = 0; i < 26; i++) begin
            {up, down, left, right} = cv[i].dir;
            tick();
            chk($sformatf("cur%0d_x", i), box_x, cv[i].ex);
            chk($sformatf("cur%0d_y", i), box_y, cv[i].ey);
            chk($sformatf("cur%0d_cx", i), c_box_x, cv[i].cx);
            chk($sformatf("cur%0d_cy", i), c_box_y, cv[i].cy);
        end
        {up, down, left, right} = '0;

        ack(1'b1);
        chk("ack_outside_val_move", move_piece, 0);
        chk("ack_outside_val_req", val_req, 0);

        sq_piece = 4'd5; sq_owner = 2'd1;
        press(1'b1, 1'b0);
        chk("foreign_piece_latch", piece_to_move, 0);
        chk("foreign_piece_x", piece_x, 0);

        sq_piece = 4'd3; sq_owner = 2'd0;
        press(1'b1, 1'b0);
        chk("src_x", piece_x, 1);
        chk("src_y", piece_y, 1);
        chk("src_piece", piece_to_move, 3);

        up = 1'b1; tick(); up = 1'b0; tick();
        up = 1'b1; tick(); up = 1'b0; tick();
        chk("dest_cursor_y", box_y, 3);

        sq_piece = 4'd0; sq_is_king = 1'b0;
        press(1'b1, 1'b0);
        chk("dst_x", move_x, 1);
        chk("dst_y", move_y, 3);
        chk("val_mem_sel", mem_sel, 1);
        n = 0;
        while (val_req && n < 50) begin
            n++;
            tick();
        end
        chk("timeout_cycles", n, 8);
        chk("timeout_mem_sel", mem_sel, 0);

        press(1'b1, 1'b0);
        chk("reval_req", val_req, 1);
        tick(); tick();
        ack(1'b0);
        chk("reject_req", val_req, 0);
        chk("reject_move", move_piece, 0);

        press(1'b1, 1'b1);
        chk("desel_priority", val_req, 0);
        press(1'b1, 1'b0);
        chk("sel_empty_stays", val_req, 0);
        chk("desel_keeps_src", piece_x, 1);
        chk("desel_keeps_dst", move_y, 3);

        sq_piece = 4'd3; sq_owner = 2'd0;
        press(1'b1, 1'b0);
        chk("resel_src_y", piece_y, 3);
        press(1'b1, 1'b0);
        chk("commit_val_req", val_req, 1);
        ack(1'b1);
        chk("commit_pulse", move_piece, 1);
        chk("commit_mem_sel", mem_sel, 2);
        chk("commit_val_req_off", val_req, 0);
        chk("commit_player_hold", current_player, 0);
        tick();
        chk("commit_pulse_end", move_piece, 0);
        chk("commit_mem_sel_end", mem_sel, 0);
        chk("player_after_0", current_player, 1);

        for (int i = 0; i < 4; i++) begin
            sq_piece = 4'd4; sq_owner = mv[i].owner; sq_is_king = 1'b0;
            press(1'b1, 1'b0);
            sq_is_king = mv[i].king;
            press(1'b1, 1'b0);
            ack(1'b1);
            chk($sformatf("mv%0d_pulse", i), move_piece, 1);
            tick();
            chk($sformatf("mv%0d_player", i), current_player, mv[i].exp_player);
            chk($sformatf("mv%0d_winning", i), winning, mv[i].exp_winning);
            chk($sformatf("mv%0d_winner", i), winner, mv[i].exp_winner);
        end
        sq_is_king = 1'b0;

        hold_bad = 0;
        for (int i = 0; i < 100; i++) begin
            logic [4:0] pat;
            pat = 5'(i);
            up = pat[0]; select = pat[1]; right = pat[2]; val_ack = pat[3]; deselect = pat[4];
            val_ok = 1'b1;
            tick();
            if (!winning || move_piece || val_req || mem_sel != 2'b00 || init_board ||
                box_x != 3'd1 || box_y != 3'd3 || winner != 2'd1)
                hold_bad++;
        end
        {up, down, left, right, select, deselect} = '0;
        val_ack = 1'b0; val_ok = 1'b0;
        chk("over_hold_violations", hold_bad, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rerst_init_board", init_board, 1);
        chk("rerst_winning", winning, 0);
        chk("rerst_player", current_player, 0);
        chk("rerst_piece_x", piece_x, 0);
        chk("rerst_box_y", box_y, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
